// File: rtl/i2c_dac_responder_if.sv
// I2C bus lines seen by the DAC responder.
// The bus owner (board pins or a bench model) drives scl_in/sda_in and
// the responder drives sda_oe, the open-drain pull-down enable for SDA.
interface i2c_dac_responder_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;

  modport master (output scl_in, output sda_in, input sda_oe);
  modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_dac_responder.sv
// I2C target that decodes DAC write frames (address, command/channel byte,
// two voltage bytes) and reports each decoded word as a one-cycle pulse.
// SCL/SDA are synchronised and glitch-filtered before edge detection.
module i2c_dac_responder #(
  parameter logic [6:0] DEV_ADDR      = 7'h0C,
  parameter bit         ADDR_MASK_LSB = 1'b1,
  parameter int         FILTER_LEN    = 3
) (
  input  logic               clk_in,
  input  logic               reset_in,
  i2c_dac_responder_if.slave bus,
  output logic               word_valid,
  output logic               chip_out,
  output logic [3:0]         cmd_out,
  output logic [3:0]         dac_id_out,
  output logic [11:0]        vol_out,
  output logic               frame_error,
  output logic               busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, DHI, DHI_ACK, DLO, DLO_ACK, IGNORE
  } state_t;

  // Ninth-clock tracking: WAIT = byte done, SCL still high; SLOT = ack bit time.
  typedef enum logic [1:0] {ACK_NONE, ACK_WAIT, ACK_SLOT} ack_ph_t;

  localparam int               CNT_W   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

  // Index 0 = SCL, index 1 = SDA.
  logic [1:0]       line_p0, line_p1, line_f, line_d;
  logic [CNT_W-1:0] flt_cnt [2];

  logic       scl, sda, scl_d, sda_d;
  logic       scl_rise, scl_fall, start_c, stop_c;
  state_t     state_q, state_d;
  ack_ph_t    ack_ph;
  logic [2:0] bit_cnt;
  logic [6:0] shift;
  logic [7:0] rx_byte;
  logic       byte_done, addr_ok, incomplete, ack_state, ack_end;
  logic       for_us, sda_oe_q, wv_d, fe_d;
  logic       chip_q;
  logic [7:0] cmd_q, dhi_q;
  logic [3:0] dlo_q;

  // Synchronise both lines, then accept a new level only after FILTER_LEN equal samples.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      line_p0    <= 2'b11;
      line_p1    <= 2'b11;
      line_f     <= 2'b11;
      line_d     <= 2'b11;
      flt_cnt[0] <= '0;
      flt_cnt[1] <= '0;
    end else begin
      line_p0 <= {bus.sda_in, bus.scl_in};
      line_p1 <= line_p0;
      line_d  <= line_f;
      for (int i = 0; i < 2; i++) begin
        if (line_p1[i] == line_f[i]) begin
          flt_cnt[i] <= '0;
        end else if (flt_cnt[i] == CNT_MAX) begin
          line_f[i]  <= line_p1[i];
          flt_cnt[i] <= '0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign scl      = line_f[0];
  assign sda      = line_f[1];
  assign scl_d    = line_d[0];
  assign sda_d    = line_d[1];
  assign scl_rise = scl & ~scl_d;
  assign scl_fall = ~scl & scl_d;
  assign start_c  = scl & scl_d & sda_d & ~sda;
  assign stop_c   = scl & scl_d & ~sda_d & sda;

  assign rx_byte    = {shift, sda};
  assign byte_done  = scl_rise && (ack_ph == ACK_NONE) && (state_q != IDLE) && (bit_cnt == 3'd7);
  assign ack_end    = scl_fall && (ack_ph == ACK_SLOT);
  assign ack_state  = state_q inside {ADDR_ACK, CMD_ACK, DHI_ACK, DLO_ACK};
  assign incomplete = state_q inside {ADDR_ACK, CMD, CMD_ACK, DHI, DHI_ACK, DLO, DLO_ACK};
  assign addr_ok    = !rx_byte[0] &&
                      (ADDR_MASK_LSB ? (rx_byte[7:2] == DEV_ADDR[6:1])
                                     : (rx_byte[7:1] == DEV_ADDR));

  assign busy       = (state_q != IDLE);
  assign bus.sda_oe = sda_oe_q;

  // Frame state register.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next state and the word/error pulse requests; START/STOP override everything.
  always_comb begin
    state_d = state_q;
    wv_d    = 1'b0;
    fe_d    = 1'b0;
    if (stop_c) begin
      state_d = IDLE;
      fe_d    = incomplete;
    end else if (start_c) begin
      state_d = ADDR;
      fe_d    = incomplete;
    end else begin
      case (state_q)
        ADDR:     if (byte_done) state_d = addr_ok ? ADDR_ACK : IGNORE;
        CMD:      if (byte_done) state_d = CMD_ACK;
        DHI:      if (byte_done) state_d = DHI_ACK;
        DLO:      if (byte_done) state_d = DLO_ACK;
        ADDR_ACK: if (ack_end)   state_d = CMD;
        CMD_ACK:  if (ack_end)   state_d = DHI;
        DHI_ACK:  if (ack_end)   state_d = DLO;
        DLO_ACK: begin
          if (ack_end) begin
            state_d = IGNORE;
            wv_d    = 1'b1;
          end
        end
        IGNORE:   if (byte_done && for_us) fe_d = 1'b1;
        default:  ;
      endcase
    end
  end

  // Bit shifting, ninth-clock phase and the ACK pull-down; START/STOP drop SDA at once.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      bit_cnt  <= '0;
      shift    <= '0;
      ack_ph   <= ACK_NONE;
      sda_oe_q <= 1'b0;
      for_us   <= 1'b0;
    end else if (start_c || stop_c) begin
      bit_cnt  <= '0;
      ack_ph   <= ACK_NONE;
      sda_oe_q <= 1'b0;
      for_us   <= 1'b0;
    end else begin
      if (scl_rise && (ack_ph == ACK_NONE) && (state_q != IDLE)) begin
        shift   <= {shift[5:0], sda};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) ack_ph <= ACK_WAIT;
      end
      if (scl_fall) begin
        if (ack_ph == ACK_WAIT) begin
          ack_ph   <= ACK_SLOT;
          sda_oe_q <= ack_state;
        end else if (ack_ph == ACK_SLOT) begin
          ack_ph   <= ACK_NONE;
          sda_oe_q <= 1'b0;
        end
      end
      if ((state_q == ADDR) && byte_done && addr_ok) for_us <= 1'b1;
    end
  end

  // Capture the received bytes of the frame in progress.
  always_ff @(posedge clk_in) begin
    if (byte_done) begin
      case (state_q)
        ADDR:    chip_q <= rx_byte[1];
        CMD:     cmd_q  <= rx_byte;
        DHI:     dhi_q  <= rx_byte;
        DLO:     dlo_q  <= rx_byte[7:4];
        default: ;
      endcase
    end
  end

  // Publish the decoded word with its pulse; outputs hold until the next word.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      word_valid  <= 1'b0;
      frame_error <= 1'b0;
      chip_out    <= 1'b0;
      cmd_out     <= '0;
      dac_id_out  <= '0;
      vol_out     <= '0;
    end else begin
      word_valid  <= wv_d;
      frame_error <= fe_d;
      if (wv_d) begin
        chip_out   <= chip_q;
        cmd_out    <= cmd_q[7:4];
        dac_id_out <= cmd_q[3:0];
        vol_out    <= {dhi_q, dlo_q};
      end
    end
  end

endmodule

// File: tb/tb_i2c_dac_responder.sv
// Bench for i2c_dac_responder: two responders share one bus, one accepting
// both chip addresses and one requiring an exact address. A frame-level
// model predicts ACKs and the word/error events per responder.
module tb_i2c_dac_responder;
  localparam logic [6:0] DEV = 7'h0C;
  localparam int         Q   = 6;

  typedef struct packed {
    bit         err;
    bit         chip;
    logic [3:0] cmd;
    logic [3:0] id;
    logic [11:0] vol;
  } ev_t;

  logic clk = 1'b0;
  logic reset_n;
  logic m_scl, m_sda;

  always #5 clk = ~clk;

  i2c_dac_responder_if bus_a ();
  i2c_dac_responder_if bus_b ();

  wire sda_line = m_sda & ~bus_a.sda_oe & ~bus_b.sda_oe;
  assign bus_a.scl_in = m_scl;
  assign bus_b.scl_in = m_scl;
  assign bus_a.sda_in = sda_line;
  assign bus_b.sda_in = sda_line;

  logic        wv_a, fe_a, busy_a, chip_a, wv_b, fe_b, busy_b, chip_b;
  logic [3:0]  cmd_a, id_a, cmd_b, id_b;
  logic [11:0] vol_a, vol_b;

  i2c_dac_responder #(.DEV_ADDR(DEV), .ADDR_MASK_LSB(1'b1), .FILTER_LEN(3)) dut_a (
    .clk_in(clk), .reset_in(reset_n), .bus(bus_a), .word_valid(wv_a), .chip_out(chip_a),
    .cmd_out(cmd_a), .dac_id_out(id_a), .vol_out(vol_a), .frame_error(fe_a), .busy(busy_a));

  i2c_dac_responder #(.DEV_ADDR(DEV), .ADDR_MASK_LSB(1'b0), .FILTER_LEN(3)) dut_b (
    .clk_in(clk), .reset_in(reset_n), .bus(bus_b), .word_valid(wv_b), .chip_out(chip_b),
    .cmd_out(cmd_b), .dac_id_out(id_b), .vol_out(vol_b), .frame_error(fe_b), .busy(busy_b));

  wire [20:0] outs_a = {chip_a, cmd_a, id_a, vol_a};
  wire [20:0] outs_b = {chip_b, cmd_b, id_b, vol_b};

  ev_t q_a[$];
  ev_t q_b[$];
  ev_t last[2];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: a frame is ours if it is a write to our address (chip bit masked for dut_a).
  function automatic bit for_us(input int dd, input logic [6:0] a, input bit rw);
    if (rw) return 1'b0;
    if (dd == 0) return a[6:1] == DEV[6:1];
    return a == DEV;
  endfunction

  task automatic push_ev(input int dd, input ev_t e);
    if (dd == 0) q_a.push_back(e);
    else         q_b.push_back(e);
  endtask

  task automatic cmp_ev(input string tag, input ev_t e, input logic wv, input logic fe,
                        input logic [20:0] outs);
    if (e.err) begin
      chk({tag, "_err_fe"}, fe, 1);
      chk({tag, "_err_wv"}, wv, 0);
    end else begin
      chk({tag, "_word_wv"}, wv, 1);
      chk({tag, "_word_fe"}, fe, 0);
      chk({tag, "_word_fields"}, outs, {e.chip, e.cmd, e.id, e.vol});
    end
  endtask

  // Scoreboard monitors: every pulse consumes one predicted event.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && (wv_a || fe_a)) begin
      if (q_a.size() == 0) chk("a_unexpected_pulse", {wv_a, fe_a}, 0);
      else cmp_ev("a", q_a.pop_front(), wv_a, fe_a, outs_a);
    end
  end

  always @(negedge clk) begin
    if (reset_n === 1'b1 && (wv_b || fe_b)) begin
      if (q_b.size() == 0) chk("b_unexpected_pulse", {wv_b, fe_b}, 0);
      else cmp_ev("b", q_b.pop_front(), wv_b, fe_b, outs_b);
    end
  end

  task automatic start_cond();
    m_scl = 1'b0; tick(Q);
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic stop_cond();
    m_scl = 1'b0; tick(Q);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit glitch, output bit ack_a, output bit ack_b);
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i]; tick(Q);
      m_scl = 1'b1; tick(3);
      if (glitch) begin
        m_sda = ~b[i]; tick(1);
        m_sda = b[i];  tick(2 * Q - 4);
      end else begin
        tick(2 * Q - 3);
      end
      m_scl = 1'b0; tick(Q);
    end
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    ack_a = bus_a.sda_oe;
    ack_b = bus_b.sda_oe;
    tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic run_frame(input logic [6:0] addr, input bit rw, input int n,
                           input logic [7:0] d [8], input bit restart_end, input bit glitch);
    bit   fu [2];
    bit   ack [2];
    ev_t  e;
    for (int dd = 0; dd < 2; dd++) fu[dd] = for_us(dd, addr, rw);
    start_cond();
    chk("a_busy_after_start", busy_a, 1);
    chk("b_busy_after_start", busy_b, 1);
    send_byte({addr, rw}, glitch, ack[0], ack[1]);
    chk("a_addr_ack", ack[0], fu[0]);
    chk("b_addr_ack", ack[1], fu[1]);
    for (int i = 0; i < n; i++) begin
      for (int dd = 0; dd < 2; dd++) begin
        if (fu[dd] && i == 2) begin
          e = '{err: 1'b0, chip: addr[0], cmd: d[0][7:4], id: d[0][3:0], vol: {d[1], d[2][7:4]}};
          push_ev(dd, e);
          last[dd] = e;
        end
        if (fu[dd] && i >= 3) push_ev(dd, '{err: 1'b1, default: '0});
      end
      send_byte(d[i], glitch, ack[0], ack[1]);
      chk("a_data_ack", ack[0], fu[0] && i < 3);
      chk("b_data_ack", ack[1], fu[1] && i < 3);
    end
    for (int dd = 0; dd < 2; dd++)
      if (fu[dd] && n < 3) push_ev(dd, '{err: 1'b1, default: '0});
    if (!restart_end) begin
      stop_cond();
      tick(8);
      chk("a_busy_after_stop", busy_a, 0);
      chk("b_busy_after_stop", busy_b, 0);
      chk("a_outputs_hold", outs_a, {last[0].chip, last[0].cmd, last[0].id, last[0].vol});
      chk("b_outputs_hold", outs_b, {last[1].chip, last[1].cmd, last[1].id, last[1].vol});
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d [8];
    bit         aa, ab;
    logic [6:0] addr;
    int         sel;

    last[0] = '0;
    last[1] = '0;
    reset_n = 1'b0;
    m_scl   = 1'b1;
    m_sda   = 1'b1;
    tick(5);
    chk("a_reset_sda_oe", bus_a.sda_oe, 0);
    chk("b_reset_sda_oe", bus_b.sda_oe, 0);
    chk("a_reset_pulses", {wv_a, fe_a}, 0);
    chk("b_reset_pulses", {wv_b, fe_b}, 0);
    chk("a_reset_busy", busy_a, 0);
    chk("b_reset_busy", busy_b, 0);
    chk("a_reset_outs", outs_a, 0);
    chk("b_reset_outs", outs_b, 0);
    reset_n = 1'b1;
    tick(10);

    // Basic word to chip 0, accepted by both responders.
    d = '{8'h35, 8'hAB, 8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(7'h0C, 1'b0, 3, d, 1'b0, 1'b0);
    // Chip 1: only the masked responder accepts.
    d = '{8'h0F, 8'hFF, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(7'h0D, 1'b0, 3, d, 1'b0, 1'b0);
    // Read request is refused and stays silent.
    d = '{8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(7'h0C, 1'b1, 1, d, 1'b0, 1'b0);
    // Truncated frame ended by STOP.
    d = '{8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(7'h0C, 1'b0, 2, d, 1'b0, 1'b0);
    // Truncated frame ended by repeated START, then a full frame.
    d = '{8'h44, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(7'h0C, 1'b0, 1, d, 1'b1, 1'b0);
    d = '{8'h9A, 8'hBC, 8'hDE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(7'h0D, 1'b0, 3, d, 1'b0, 1'b0);
    // Extra fifth byte after a complete word.
    d = '{8'h35, 8'hAB, 8'hC0, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(7'h0C, 1'b0, 4, d, 1'b0, 1'b0);

    // Short SDA glitch on an idle bus must not look like START.
    m_sda = 1'b0; tick(1);
    m_sda = 1'b1; tick(12);
    chk("a_idle_glitch_busy", busy_a, 0);
    chk("b_idle_glitch_busy", busy_b, 0);
    d = '{8'h7E, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(7'h0C, 1'b0, 3, d, 1'b0, 1'b1);

    // Reset while SCL is high in the middle of the third byte.
    start_cond();
    send_byte({DEV, 1'b0}, 1'b0, aa, ab);
    chk("a_rst_addr_ack", aa, 1);
    chk("b_rst_addr_ack", ab, 1);
    send_byte(8'h35, 1'b0, aa, ab);
    chk("a_rst_cmd_ack", aa, 1);
    chk("b_rst_cmd_ack", ab, 1);
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(3);
    reset_n = 1'b0;
    tick(2);
    chk("a_midrst_outs", outs_a, 0);
    chk("b_midrst_outs", outs_b, 0);
    chk("a_midrst_sda_oe", bus_a.sda_oe, 0);
    chk("b_midrst_sda_oe", bus_b.sda_oe, 0);
    chk("a_midrst_busy", busy_a, 0);
    tick(4);
    reset_n = 1'b1;
    last[0] = '0;
    last[1] = '0;
    tick(10);
    chk("a_post_rst_busy", busy_a, 0);
    chk("b_post_rst_busy", busy_b, 0);
    d = '{8'hC3, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(7'h0C, 1'b0, 3, d, 1'b0, 1'b0);

    // Randomised frames.
    for (int f = 0; f < 25; f++) begin
      sel = $urandom_range(0, 3);
      if (sel == 0 || sel == 2) addr = 7'h0C;
      else if (sel == 1)        addr = 7'h0D;
      else                      addr = 7'($urandom_range(0, 127));
      for (int k = 0; k < 8; k++) d[k] = 8'($urandom_range(0, 255));
      run_frame(addr, ($urandom_range(0, 9) == 0), $urandom_range(0, 5), d,
                (f != 24) && ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    tick(50);
    chk("a_events_outstanding", q_a.size(), 0);
    chk("b_events_outstanding", q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
